wb_commit_tracer: RTL and testbench
===================================

// Module: wb_commit_tracer
// PURPOSE
//   Parametrised write-back commit tracer for the pipelined MIPS system; successor to single-register probing.
//   Records every WB-stage register commit and exception into a circular trace buffer of DEPTH entries.
//   Keeps a shadow copy of one selectable "watched" register.
//   Sits beside the pipeline, fed from the WB stage outputs; drained through a valid/ready read port.
// PARAMETERS
//   DATA_W   32  width of WB_write_data
//   ADDR_W   5   width of register address
//   PTR_W    4   buffer pointer width; DEPTH = 2**PTR_W (16 entries)
// PORTS
//   SYS_clk             in   1                     clock, all state on rising edge
//   SYS_reset           in   1                     synchronous, active-high reset
//   trc_enable          in   1                     1 = capture commits, 0 = idle (buffer retained)
//   trc_mode            in   1                     0 = wrap (overwrite oldest), 1 = stop (drop new when full)
//   WB_RegWrite_signal  in   1                     WB stage register write strobe
//   WB_write_register   in   ADDR_W                WB destination register
//   WB_write_data       in   DATA_W                WB write data
//   WB_exception_signal in   3                     WB exception code, 0 = none
//   watch_reg_add       in   ADDR_W                register number to shadow
//   watch_reg_data      out  DATA_W                last value committed to watch_reg_add
//   watch_hit           out  1                     one-cycle pulse after a commit to the watched register
//   rd_valid            out  1                     trace entry available
//   rd_ready            in   1                     consumer accepts entry
//   rd_data             out  3+ADDR_W+DATA_W       oldest entry {exc[2:0], reg, data}
//   trc_count           out  PTR_W+1               entries held, 0..DEPTH
//   trc_overflow        out  1                     sticky: an entry was lost or overwritten
//   trc_frozen          out  1                     capture stopped by an exception
// BEHAVIOUR
//   Reset (SYS_reset=1 at edge): all outputs and pointers are 0, the FSM enters IDLE and the shadow is cleared.
//     Reset wins over every other event in the same cycle; a reset mid-drain discards the buffer.
//   FSM, evaluated at each edge:
//     IDLE   -> RUN when trc_enable=1.
//     RUN    -> IDLE when trc_enable=0.
//     RUN    -> FROZEN when a captured commit carries exc!=0; that entry is still written.
//     FROZEN -> IDLE only when trc_enable=0. trc_frozen=1 exactly in FROZEN.
//   Capture condition, RUN only:
//     (WB_RegWrite_signal && WB_write_register!=0) || WB_exception_signal!=0.
//     Writes to register 0 without an exception are never traced.
//   Latency: a commit sampled at edge N is visible at rd_data/trc_count right after edge N (1 cycle).
//   Read port:
//     first-word fall-through; rd_valid = (trc_count!=0); rd_data = entry at read pointer.
//     Pop happens on an edge where rd_valid && rd_ready; reads are allowed in every FSM state.
//     rd_data is stable while rd_valid=1 and rd_ready=0, except for a wrap-mode overwrite.
//   Count rules:
//     push only: +1
//     pop only: -1
//     push+pop: unchanged (both pointers advance)
//   Full (count==DEPTH), push, no pop:
//     wrap mode: overwrite oldest; both pointers advance; count stays DEPTH; trc_overflow<=1.
//     stop mode: entry dropped; pointers unchanged; trc_overflow<=1.
//   Full, push and pop in the same cycle: no loss, no overflow, in either mode.
//   Empty, pop: impossible (rd_valid=0); an empty push+rd_ready behaves as push only.
//   Pointers wrap modulo DEPTH.
//   trc_overflow clears only on reset.
//   Watch logic runs in every FSM state and is independent of trc_enable:
//     on an edge with WB_RegWrite_signal && WB_write_register==watch_reg_add && watch_reg_add!=0,
//     watch_reg_data <= WB_write_data and watch_hit <= 1; otherwise watch_hit <= 0.
//     Changing watch_reg_add does not clear watch_reg_data.
// TESTING
//   1 Reset pulse mid-stream -> all outputs 0 next cycle, rd_valid=0, state IDLE.
//   2 RUN; commit r8=0x0000_0005, r9=0x1234; r0=0xFFFF
//       -> count=2; pops return {0,8,0x5} then {0,9,0x1234}; r0 commit absent.
//   3 Wrap mode; 17 commits r1=1..17 with rd_ready=0
//       -> count=16, overflow=1, first pop returns data 2, last pop returns 17.
//   4 Stop mode; same 17 commits
//       -> count=16, overflow=1, pops return 1..16; then a full push+pop on the same edge gives no new overflow.
//   5 Commit with exc=3'b010 on r4
//       -> entry {2,4,data} stored, trc_frozen=1, later commits ignored until trc_enable=0 gives IDLE.
//   6 watch_reg_add=8; write r8=0xDEADBEEF while trc_enable=0
//       -> watch_reg_data=0xDEADBEEF, watch_hit high one cycle, count=0.

Source files
------------

// File: rtl/wb_commit_tracer_if.sv
// Bus bundle between the WB stage, the trace consumer and the commit tracer.
// The WB stage drives the commit fields. The consumer drains the trace through the rd_* port.
//
// Read handshake (valid/ready):
//   - An entry transfers on every rising edge where rd_valid && rd_ready.
//   - rd_valid never depends on rd_ready.
//   - While rd_valid=1 and rd_ready=0, rd_data holds its value, except when a wrap-mode overwrite
//     replaces the oldest entry.
//   - The consumer may hold rd_ready high at any time.
interface wb_commit_tracer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                       WB_RegWrite_signal;
  logic [ADDR_W-1:0]          WB_write_register;
  logic [DATA_W-1:0]          WB_write_data;
  logic [2:0]                 WB_exception_signal;
  logic                       rd_valid;
  logic                       rd_ready;
  logic [3+ADDR_W+DATA_W-1:0] rd_data;

  modport master (
    output WB_RegWrite_signal, WB_write_register, WB_write_data, WB_exception_signal, rd_ready,
    input  rd_valid, rd_data
  );

  modport slave (
    input  WB_RegWrite_signal, WB_write_register, WB_write_data, WB_exception_signal, rd_ready,
    output rd_valid, rd_data
  );
endinterface

// File: rtl/wb_commit_tracer.sv
// Write-back commit tracer: captures WB register commits and exceptions into a
// circular buffer, shadows one watched register, and exposes a FWFT read port.
module wb_commit_tracer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PTR_W  = 4
) (
  input  logic                SYS_clk,
  input  logic                SYS_reset,
  wb_commit_tracer_if.slave   bus,
  input  logic                trc_enable,
  input  logic                trc_mode,
  input  logic [ADDR_W-1:0]   watch_reg_add,
  output logic [DATA_W-1:0]   watch_reg_data,
  output logic                watch_hit,
  output logic [PTR_W:0]      trc_count,
  output logic                trc_overflow,
  output logic                trc_frozen,
  output logic [1:0]          state_dbg
);
  localparam int ENT_W = 3 + ADDR_W + DATA_W;
  localparam int DEPTH = 1 << PTR_W;
  localparam logic [PTR_W:0] DEPTH_CNT = {1'b1, {PTR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FROZEN = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             capture, push, pop, full;
  logic             mem_we, adv_wr, adv_rd, cnt_inc, cnt_dec, set_ovf;
  logic [ENT_W-1:0] entry;

  assign entry   = {bus.WB_exception_signal, bus.WB_write_register, bus.WB_write_data};
  assign capture = (state == RUN) &&
                   ((bus.WB_RegWrite_signal && (bus.WB_write_register != '0)) ||
                    (bus.WB_exception_signal != 3'b000));
  assign push    = capture;
  assign pop     = (trc_count != '0) && bus.rd_ready;
  assign full    = (trc_count == DEPTH_CNT);

  assign bus.rd_valid = (trc_count != '0);
  assign bus.rd_data  = bus.rd_valid ? mem[rd_ptr] : '0;
  assign trc_frozen   = (state == FROZEN);
  assign state_dbg    = state;

  // FSM state register
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) state <= IDLE;
    else           state <= state_nxt;
  end

  // FSM next state; disabling takes priority over freezing
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trc_enable) state_nxt = RUN;
      RUN: begin
        if (!trc_enable)                                        state_nxt = IDLE;
        else if (capture && (bus.WB_exception_signal != 3'b000)) state_nxt = FROZEN;
      end
      FROZEN:  if (!trc_enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Buffer control: decide writes, pointer moves, count change and overflow
  always_comb begin
    mem_we  = 1'b0;
    adv_wr  = 1'b0;
    adv_rd  = 1'b0;
    cnt_inc = 1'b0;
    cnt_dec = 1'b0;
    set_ovf = 1'b0;
    if (push && pop) begin
      // Slot being freed is refilled in the same cycle, so nothing is lost even when full
      mem_we = 1'b1;
      adv_wr = 1'b1;
      adv_rd = 1'b1;
    end else if (push) begin
      if (!full) begin
        mem_we  = 1'b1;
        adv_wr  = 1'b1;
        cnt_inc = 1'b1;
      end else if (!trc_mode) begin
        // Wrap: write over the oldest entry (wr_ptr == rd_ptr when full)
        mem_we  = 1'b1;
        adv_wr  = 1'b1;
        adv_rd  = 1'b1;
        set_ovf = 1'b1;
      end else begin
        set_ovf = 1'b1;
      end
    end else if (pop) begin
      adv_rd  = 1'b1;
      cnt_dec = 1'b1;
    end
  end

  // Pointers, count and sticky overflow
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      trc_count    <= '0;
      trc_overflow <= 1'b0;
    end else begin
      if (adv_wr)  wr_ptr    <= wr_ptr + 1'b1;
      if (adv_rd)  rd_ptr    <= rd_ptr + 1'b1;
      if (cnt_inc) trc_count <= trc_count + 1'b1;
      if (cnt_dec) trc_count <= trc_count - 1'b1;
      if (set_ovf) trc_overflow <= 1'b1;
    end
  end

  // Trace storage; contents are don't-care until written since rd_data is gated by rd_valid
  always_ff @(posedge SYS_clk) begin
    if (mem_we) mem[wr_ptr] <= entry;
  end

  // Watched-register shadow, active in every state
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      watch_reg_data <= '0;
      watch_hit      <= 1'b0;
    end else if (bus.WB_RegWrite_signal && (bus.WB_write_register == watch_reg_add) &&
                 (watch_reg_add != '0)) begin
      watch_reg_data <= bus.WB_write_data;
      watch_hit      <= 1'b1;
    end else begin
      watch_hit      <= 1'b0;
    end
  end
endmodule

// File: tb/tb_wb_commit_tracer.sv
// Directed testbench for wb_commit_tracer with a scoreboard queue of expected trace entries.
module tb_wb_commit_tracer;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int PTR_W  = 4;
  localparam int W      = 3 + ADDR_W + DATA_W;
  localparam int S_IDLE = 0, S_RUN = 1, S_FROZEN = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              enable, mode;
  logic [ADDR_W-1:0] watch_add;
  logic [DATA_W-1:0] watch_data;
  logic              watch_hit, ovf, frozen;
  logic [PTR_W:0]    count;
  logic [1:0]        state_dbg;

  wb_commit_tracer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  wb_commit_tracer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PTR_W(PTR_W)) dut (
    .SYS_clk(clk), .SYS_reset(rst), .bus(bus),
    .trc_enable(enable), .trc_mode(mode), .watch_reg_add(watch_add),
    .watch_reg_data(watch_data), .watch_hit(watch_hit), .trc_count(count),
    .trc_overflow(ovf), .trc_frozen(frozen), .state_dbg(state_dbg)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic         exp_run;
  logic         exp_ovf;
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    exp_run = 1'b0;
    exp_ovf = 1'b0;
  endtask

  task automatic start_run(input logic m);
    mode   = m;
    enable = 1'b1;
    tick();
    exp_run = 1'b1;
  endtask

  // drive one WB cycle and update the expected trace
  task automatic commit(input logic wr, input logic [ADDR_W-1:0] r,
                        input logic [DATA_W-1:0] d, input logic [2:0] e);
    logic         cap;
    logic [W-1:0] junk;
    cap = exp_run && ((wr && r != 0) || e != 0);
    bus.WB_RegWrite_signal  = wr;
    bus.WB_write_register   = r;
    bus.WB_write_data       = d;
    bus.WB_exception_signal = e;
    tick();
    bus.WB_RegWrite_signal  = 1'b0;
    bus.WB_exception_signal = 3'b000;
    if (cap) begin
      if (exp_q.size() == (1 << PTR_W)) begin
        exp_ovf = 1'b1;
        if (!mode) begin
          junk = exp_q.pop_front();
          exp_q.push_back({e, r, d});
        end
      end else begin
        exp_q.push_back({e, r, d});
      end
      if (e != 0) exp_run = 1'b0;
    end
  endtask

  // push and pop on the same edge
  task automatic commit_pop(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
    logic [W-1:0] head;
    head = exp_q.pop_front();
    check("pushpop_head", bus.rd_data, head);
    bus.rd_ready = 1'b1;
    commit(1'b1, r, d, 3'b000);
    bus.rd_ready = 1'b0;
  endtask

  // pop every entry and compare against the scoreboard, bounded
  task automatic drain(input string tag);
    logic [W-1:0] exp_e;
    for (int i = 0; i < 40 && bus.rd_valid; i++) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $error("FAIL %s_extra observed=0x%0h expected=none", tag, bus.rd_data);
      end else begin
        exp_e = exp_q.pop_front();
        check(tag, bus.rd_data, exp_e);
      end
      bus.rd_ready = 1'b1;
      tick();
      bus.rd_ready = 1'b0;
    end
    check({tag, "_left"}, exp_q.size(), 0);
    check({tag, "_valid"}, bus.rd_valid, 1'b0);
  endtask

  initial begin
    enable = 1'b0; mode = 1'b0; watch_add = '0;
    bus.WB_RegWrite_signal = 1'b0; bus.WB_write_register = '0;
    bus.WB_write_data = '0; bus.WB_exception_signal = 3'b000; bus.rd_ready = 1'b0;
    exp_run = 1'b0; exp_ovf = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // 1: reset pulse mid-stream clears everything
    watch_add = 5'd3;
    start_run(1'b0);
    commit(1'b1, 5'd3, 32'hAAAA, 3'b000);
    commit(1'b1, 5'd6, 32'hBBBB, 3'b000);
    check("pre_reset_count", count, exp_q.size());
    check("pre_reset_watch", watch_data, 32'hAAAA);
    do_reset();
    check("rst_count", count, 0);
    check("rst_valid", bus.rd_valid, 1'b0);
    check("rst_data", bus.rd_data, 0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_frozen", frozen, 1'b0);
    check("rst_watch", watch_data, 0);
    check("rst_hit", watch_hit, 1'b0);
    check("rst_state", state_dbg, S_IDLE);
    enable = 1'b0;
    watch_add = '0;
    tick();

    // 2: basic capture, r0 not traced
    start_run(1'b0);
    check("run_state", state_dbg, S_RUN);
    commit(1'b1, 5'd8, 32'h0000_0005, 3'b000);
    check("lat_count", count, 1);
    check("lat_data", bus.rd_data, {3'b000, 5'd8, 32'h5});
    commit(1'b1, 5'd9, 32'h0000_1234, 3'b000);
    commit(1'b1, 5'd0, 32'h0000_FFFF, 3'b000);
    commit(1'b0, 5'd10, 32'h0000_7777, 3'b000);
    check("t2_count", count, 2);
    drain("t2_pop");

    // 3: wrap mode overflow
    for (int i = 1; i <= 17; i++) commit(1'b1, 5'd1, i, 3'b000);
    check("t3_count", count, 16);
    check("t3_ovf", ovf, exp_ovf);
    check("t3_first", bus.rd_data, {3'b000, 5'd1, 32'd2});
    drain("t3_pop");
    check("t3_ovf_sticky", ovf, 1'b1);

    // 4: stop mode overflow, then full push+pop
    enable = 1'b0;
    do_reset();
    start_run(1'b1);
    for (int i = 1; i <= 17; i++) commit(1'b1, 5'd1, i, 3'b000);
    check("t4_count", count, 16);
    check("t4_ovf", ovf, exp_ovf);
    drain("t4_pop");
    enable = 1'b0;
    do_reset();
    start_run(1'b1);
    for (int i = 1; i <= 16; i++) commit(1'b1, 5'd2, 32'h100 + i, 3'b000);
    check("t4_full_ovf", ovf, 1'b0);
    commit_pop(5'd3, 32'h0000_0999);
    check("t4_pp_count", count, 16);
    check("t4_pp_ovf", ovf, 1'b0);
    drain("t4_pp_pop");

    // 5: exception freezes capture
    enable = 1'b0;
    do_reset();
    start_run(1'b0);
    commit(1'b1, 5'd4, 32'h0000_0077, 3'b010);
    check("t5_frozen", frozen, 1'b1);
    check("t5_state", state_dbg, S_FROZEN);
    check("t5_count", count, 1);
    commit(1'b1, 5'd5, 32'h0000_0088, 3'b000);
    commit(1'b0, 5'd0, 32'h0, 3'b001);
    check("t5_ignored", count, 1);
    enable = 1'b0;
    tick();
    check("t5_idle", state_dbg, S_IDLE);
    check("t5_unfrozen", frozen, 1'b0);
    drain("t5_pop");

    // 6: watch register while tracing disabled
    watch_add = 5'd8;
    commit(1'b1, 5'd8, 32'hDEAD_BEEF, 3'b000);
    check("t6_watch", watch_data, 32'hDEAD_BEEF);
    check("t6_hit", watch_hit, 1'b1);
    check("t6_count", count, 0);
    tick();
    check("t6_hit_pulse", watch_hit, 1'b0);
    watch_add = 5'd9;
    commit(1'b1, 5'd8, 32'h1111_1111, 3'b000);
    check("t6_keep", watch_data, 32'hDEAD_BEEF);
    check("t6_nohit", watch_hit, 1'b0);
    watch_add = 5'd0;
    commit(1'b1, 5'd0, 32'h2222_2222, 3'b000);
    check("t6_r0", watch_data, 32'hDEAD_BEEF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
